// File: rtl/commit_nway_if.sv
// commit_nway_if: MEM -> commit bus for one N-issue group.
//   Inputs (*_i, flush, flush_cause, exc_lane_i, stall) are driven by the MEM side.
//   Outputs (*_o, commit_cnt_o) are driven by the commit register.
//   master: MEM/producer side.  slave: commit_nway.
interface commit_nway_if #(
  parameter int LANES = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PCW   = 32,
  parameter int LW    = 2
);
  logic                 flush;
  logic                 flush_cause;
  logic [LW-1:0]        exc_lane_i;
  logic [4:0]           stall;
  logic [LANES-1:0]     valid_i;
  logic [LANES*PCW-1:0] pc_i;
  logic [LANES-1:0]     we_i;
  logic [LANES*AW-1:0]  waddr_i;
  logic [LANES*DW-1:0]  wdata_i;
  logic [DW-1:0]        hi_i;
  logic [DW-1:0]        lo_i;
  logic                 whilo_i;
  logic                 llbit_i;
  logic                 llbit_we_i;
  logic                 cp0_we_i;
  logic [AW-1:0]        cp0_waddr_i;
  logic [2:0]           cp0_wsel_i;
  logic [DW-1:0]        cp0_wdata_i;

  logic [LANES-1:0]     valid_o;
  logic [LANES*PCW-1:0] pc_o;
  logic [LANES-1:0]     we_o;
  logic [LANES*AW-1:0]  waddr_o;
  logic [LANES*DW-1:0]  wdata_o;
  logic [DW-1:0]        hi_o;
  logic [DW-1:0]        lo_o;
  logic                 whilo_o;
  logic                 llbit_o;
  logic                 llbit_we_o;
  logic                 cp0_we_o;
  logic [AW-1:0]        cp0_waddr_o;
  logic [2:0]           cp0_wsel_o;
  logic [DW-1:0]        cp0_wdata_o;
  logic [LW-1:0]        commit_cnt_o;

  modport master (
    output flush, flush_cause, exc_lane_i, stall, valid_i, pc_i, we_i, waddr_i, wdata_i,
           hi_i, lo_i, whilo_i, llbit_i, llbit_we_i, cp0_we_i, cp0_waddr_i, cp0_wsel_i,
           cp0_wdata_i,
    input  valid_o, pc_o, we_o, waddr_o, wdata_o, hi_o, lo_o, whilo_o, llbit_o, llbit_we_o,
           cp0_we_o, cp0_waddr_o, cp0_wsel_o, cp0_wdata_o, commit_cnt_o
  );

  modport slave (
    input  flush, flush_cause, exc_lane_i, stall, valid_i, pc_i, we_i, waddr_i, wdata_i,
           hi_i, lo_i, whilo_i, llbit_i, llbit_we_i, cp0_we_i, cp0_waddr_i, cp0_wsel_i,
           cp0_wdata_i,
    output valid_o, pc_o, we_o, waddr_o, wdata_o, hi_o, lo_o, whilo_o, llbit_o, llbit_we_o,
           cp0_we_o, cp0_waddr_o, cp0_wsel_o, cp0_wdata_o, commit_cnt_o
  );
endinterface

// File: rtl/commit_nway.sv
// commit_nway: commit-stage pipeline register for an N-issue in-order MIPS core.
//   Registers one issue group between MEM and architectural state (latency 1).
//   Handles exception squashing of the excepting lane and all younger lanes,
//   MEM-stall bubbles, commit-stall holds, and reports the group occupancy.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   bus (slave)    commit_nway_if: flush/stall control, per-lane inputs, registered outputs
//   retired_clr_i  (COMMIT_RETIRE_CNT_EN only) clear retired-instruction counter
//   retired_o      (COMMIT_RETIRE_CNT_EN only) 64-bit retired-instruction counter
// Optional feature macro: COMMIT_RETIRE_CNT_EN
module commit_nway #(
  parameter int LANES = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PCW   = 32,
  parameter int LW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  commit_nway_if.slave bus
`ifdef COMMIT_RETIRE_CNT_EN
  ,
  input  logic         retired_clr_i,
  output logic [63:0]  retired_o
`endif
);

  localparam int unsigned LANES_U = LANES;

  logic                 exc_flush;
  logic                 hold;
  logic                 ctl_keep;
  logic                 side_keep;
  int unsigned          exc_eff;
  logic [LANES-1:0]     lane_keep;

  logic [LANES-1:0]     n_valid;
  logic [LANES-1:0]     n_we;
  logic [LANES*AW-1:0]  n_waddr;
  logic [LANES*DW-1:0]  n_wdata;
  logic [LANES*PCW-1:0] n_pc;
  logic                 n_whilo;
  logic [DW-1:0]        n_hi;
  logic [DW-1:0]        n_lo;
  logic                 n_llbit;
  logic                 n_llbit_we;
  logic                 n_cp0_we;
  logic [AW-1:0]        n_cp0_waddr;
  logic [2:0]           n_cp0_wsel;
  logic [DW-1:0]        n_cp0_wdata;
  logic [LW-1:0]        n_cnt;

  // Only MEM/commit stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{bus.stall[4], bus.stall[1:0]};

  // The priority chain is folded into keep masks: each output group is either
  // loaded from the (masked) inputs or zeroed; hold simply skips the load.
  always_comb begin
    exc_flush = bus.flush & bus.flush_cause;
    hold      = !exc_flush & bus.stall[2] & bus.stall[3];
    exc_eff   = (32'(bus.exc_lane_i) >= LANES_U) ? LANES_U - 1 : 32'(bus.exc_lane_i);

    // CP0 / LLbit writes survive only a plain latch, never an exception flush.
    ctl_keep  = !exc_flush & !bus.stall[2];
    // Lane-0 HI/LO/LLbit value survive an exception only if lane 0 is older.
    side_keep = exc_flush ? (exc_eff != 0) : !bus.stall[2];

    lane_keep = '0;
    for (int unsigned k = 0; k < LANES_U; k++) begin
      lane_keep[k] = exc_flush ? (k < exc_eff) : !bus.stall[2];
    end

    n_valid = bus.valid_i & lane_keep;
    n_we    = bus.we_i & n_valid;
    n_waddr = '0;
    n_wdata = '0;
    n_pc    = '0;
    for (int unsigned k = 0; k < LANES_U; k++) begin
      if (n_valid[k]) n_waddr[k*AW +: AW] = bus.waddr_i[k*AW +: AW];
      if (lane_keep[k]) begin
        n_wdata[k*DW +: DW]   = bus.wdata_i[k*DW +: DW];
        n_pc[k*PCW +: PCW]    = bus.pc_i[k*PCW +: PCW];
      end
    end

    n_whilo     = side_keep & bus.whilo_i & n_valid[0];
    n_hi        = side_keep ? bus.hi_i : '0;
    n_lo        = side_keep ? bus.lo_i : '0;
    n_llbit     = side_keep & bus.llbit_i;
    n_llbit_we  = ctl_keep & bus.llbit_we_i & n_valid[0];
    n_cp0_we    = ctl_keep & bus.cp0_we_i & n_valid[0];
    n_cp0_waddr = ctl_keep ? bus.cp0_waddr_i : '0;
    n_cp0_wsel  = ctl_keep ? bus.cp0_wsel_i : '0;
    n_cp0_wdata = ctl_keep ? bus.cp0_wdata_i : '0;

    n_cnt = '0;
    for (int unsigned k = 0; k < LANES_U; k++) begin
      n_cnt = n_cnt + LW'(n_valid[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_o      <= '0;
      bus.we_o         <= '0;
      bus.waddr_o      <= '0;
      bus.wdata_o      <= '0;
      bus.pc_o         <= '0;
      bus.whilo_o      <= '0;
      bus.hi_o         <= '0;
      bus.lo_o         <= '0;
      bus.llbit_o      <= '0;
      bus.llbit_we_o   <= '0;
      bus.cp0_we_o     <= '0;
      bus.cp0_waddr_o  <= '0;
      bus.cp0_wsel_o   <= '0;
      bus.cp0_wdata_o  <= '0;
      bus.commit_cnt_o <= '0;
    end else if (!hold) begin
      bus.valid_o      <= n_valid;
      bus.we_o         <= n_we;
      bus.waddr_o      <= n_waddr;
      bus.wdata_o      <= n_wdata;
      bus.pc_o         <= n_pc;
      bus.whilo_o      <= n_whilo;
      bus.hi_o         <= n_hi;
      bus.lo_o         <= n_lo;
      bus.llbit_o      <= n_llbit;
      bus.llbit_we_o   <= n_llbit_we;
      bus.cp0_we_o     <= n_cp0_we;
      bus.cp0_waddr_o  <= n_cp0_waddr;
      bus.cp0_wsel_o   <= n_cp0_wsel;
      bus.cp0_wdata_o  <= n_cp0_wdata;
      bus.commit_cnt_o <= n_cnt;
    end
  end

`ifdef COMMIT_RETIRE_CNT_EN
  // Accumulates the already-registered count, so it trails commit by one cycle.
  always_ff @(posedge clk) begin
    if (rst || retired_clr_i) retired_o <= '0;
    else                      retired_o <= retired_o + 64'(bus.commit_cnt_o);
  end
`endif

endmodule

// File: tb/tb_commit_nway.sv
module tb_commit_nway;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [31:0] wd;
  } lane_t;

  typedef struct packed {
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llbit;
    logic        llbit_we;
    logic        cp0_we;
    logic [4:0]  cp0_wa;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wd;
    logic [2:0]  cnt;
  } side_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus (4 lanes; the 2-lane DUT sees lanes 0..1)
  logic        s_rst, s_flush, s_cause, s_clr;
  logic [2:0]  s_exc;
  logic [4:0]  s_stall;
  logic [3:0]  s_valid, s_we;
  logic [4:0]  s_wa [4];
  logic [31:0] s_wd [4];
  logic [31:0] s_pc [4];
  logic [31:0] s_hi, s_lo, s_cp0_wd;
  logic        s_whilo, s_llbit, s_llbit_we, s_cp0_we;
  logic [4:0]  s_cp0_wa;
  logic [2:0]  s_cp0_sel;

  // Reference model state: [0] = 2-lane DUT, [1] = 4-lane DUT
  lane_t       ml [2][4];
  side_t       ms [2];
  logic [63:0] mret [2];

  commit_nway_if #(.LANES(2), .AW(5), .DW(32), .PCW(32), .LW(2)) bus2();
  commit_nway_if #(.LANES(4), .AW(5), .DW(32), .PCW(32), .LW(3)) bus4();

`ifdef COMMIT_RETIRE_CNT_EN
  logic [63:0] ret2, ret4;
`endif

  commit_nway #(.LANES(2), .AW(5), .DW(32), .PCW(32), .LW(2)) dut2 (
    .clk(clk), .rst(s_rst), .bus(bus2)
`ifdef COMMIT_RETIRE_CNT_EN
    , .retired_clr_i(s_clr), .retired_o(ret2)
`endif
  );

  commit_nway #(.LANES(4), .AW(5), .DW(32), .PCW(32), .LW(3)) dut4 (
    .clk(clk), .rst(s_rst), .bus(bus4)
`ifdef COMMIT_RETIRE_CNT_EN
    , .retired_clr_i(s_clr), .retired_o(ret4)
`endif
  );

  assign bus2.flush       = s_flush;
  assign bus2.flush_cause = s_cause;
  assign bus2.exc_lane_i  = s_exc[1:0];
  assign bus2.stall       = s_stall;
  assign bus2.valid_i     = s_valid[1:0];
  assign bus2.we_i        = s_we[1:0];
  assign bus2.pc_i        = {s_pc[1], s_pc[0]};
  assign bus2.waddr_i     = {s_wa[1], s_wa[0]};
  assign bus2.wdata_i     = {s_wd[1], s_wd[0]};
  assign bus2.hi_i        = s_hi;
  assign bus2.lo_i        = s_lo;
  assign bus2.whilo_i     = s_whilo;
  assign bus2.llbit_i     = s_llbit;
  assign bus2.llbit_we_i  = s_llbit_we;
  assign bus2.cp0_we_i    = s_cp0_we;
  assign bus2.cp0_waddr_i = s_cp0_wa;
  assign bus2.cp0_wsel_i  = s_cp0_sel;
  assign bus2.cp0_wdata_i = s_cp0_wd;

  assign bus4.flush       = s_flush;
  assign bus4.flush_cause = s_cause;
  assign bus4.exc_lane_i  = s_exc;
  assign bus4.stall       = s_stall;
  assign bus4.valid_i     = s_valid;
  assign bus4.we_i        = s_we;
  assign bus4.pc_i        = {s_pc[3], s_pc[2], s_pc[1], s_pc[0]};
  assign bus4.waddr_i     = {s_wa[3], s_wa[2], s_wa[1], s_wa[0]};
  assign bus4.wdata_i     = {s_wd[3], s_wd[2], s_wd[1], s_wd[0]};
  assign bus4.hi_i        = s_hi;
  assign bus4.lo_i        = s_lo;
  assign bus4.whilo_i     = s_whilo;
  assign bus4.llbit_i     = s_llbit;
  assign bus4.llbit_we_i  = s_llbit_we;
  assign bus4.cp0_we_i    = s_cp0_we;
  assign bus4.cp0_waddr_i = s_cp0_wa;
  assign bus4.cp0_wsel_i  = s_cp0_sel;
  assign bus4.cp0_wdata_i = s_cp0_wd;

  // An instruction as it should appear at commit: an empty slot never writes.
  function automatic lane_t take(input int k);
    lane_t t;
    t.v  = s_valid[k];
    t.we = s_valid[k] && s_we[k];
    t.wa = s_valid[k] ? s_wa[k] : 5'd0;
    t.pc = s_pc[k];
    t.wd = s_wd[k];
    return t;
  endfunction

  task automatic model(input int d, input int lanes, input int exc);
    int e;
    int n;
    if (s_rst || s_clr) mret[d] = 64'd0;
    else                mret[d] = mret[d] + 64'(ms[d].cnt);

    if (s_rst) begin
      for (int k = 0; k < 4; k++) ml[d][k] = '0;
      ms[d] = '0;
    end else if (s_flush && s_cause) begin
      e = (exc >= lanes) ? lanes - 1 : exc;
      for (int k = 0; k < 4; k++) ml[d][k] = (k < e) ? take(k) : lane_t'('0);
      ms[d] = '0;
      if (e > 0) begin
        ms[d].whilo = s_whilo && s_valid[0];
        ms[d].hi    = s_hi;
        ms[d].lo    = s_lo;
        ms[d].llbit = s_llbit;
      end
    end else if (s_stall[2] && !s_stall[3]) begin
      for (int k = 0; k < 4; k++) ml[d][k] = '0;
      ms[d] = '0;
    end else if (!s_stall[2]) begin
      for (int k = 0; k < lanes; k++) ml[d][k] = take(k);
      ms[d].whilo    = s_whilo && s_valid[0];
      ms[d].hi       = s_hi;
      ms[d].lo       = s_lo;
      ms[d].llbit    = s_llbit;
      ms[d].llbit_we = s_llbit_we && s_valid[0];
      ms[d].cp0_we   = s_cp0_we && s_valid[0];
      ms[d].cp0_wa   = s_cp0_wa;
      ms[d].cp0_sel  = s_cp0_sel;
      ms[d].cp0_wd   = s_cp0_wd;
    end
    n = 0;
    for (int k = 0; k < lanes; k++) n += int'(ml[d][k].v);
    ms[d].cnt = 3'(n);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++)
      chk($sformatf("l2_lane%0d", k),
          128'({bus2.valid_o[k], bus2.we_o[k], bus2.waddr_o[k*5 +: 5],
                bus2.pc_o[k*32 +: 32], bus2.wdata_o[k*32 +: 32]}), 128'(ml[0][k]));
    for (int k = 0; k < 4; k++)
      chk($sformatf("l4_lane%0d", k),
          128'({bus4.valid_o[k], bus4.we_o[k], bus4.waddr_o[k*5 +: 5],
                bus4.pc_o[k*32 +: 32], bus4.wdata_o[k*32 +: 32]}), 128'(ml[1][k]));
    chk("l2_side", 128'({bus2.whilo_o, bus2.hi_o, bus2.lo_o, bus2.llbit_o, bus2.llbit_we_o,
                         bus2.cp0_we_o, bus2.cp0_waddr_o, bus2.cp0_wsel_o, bus2.cp0_wdata_o,
                         1'b0, bus2.commit_cnt_o}), 128'(ms[0]));
    chk("l4_side", 128'({bus4.whilo_o, bus4.hi_o, bus4.lo_o, bus4.llbit_o, bus4.llbit_we_o,
                         bus4.cp0_we_o, bus4.cp0_waddr_o, bus4.cp0_wsel_o, bus4.cp0_wdata_o,
                         bus4.commit_cnt_o}), 128'(ms[1]));
`ifdef COMMIT_RETIRE_CNT_EN
    chk("l2_retired", 128'(ret2), 128'(mret[0]));
    chk("l4_retired", 128'(ret4), 128'(mret[1]));
`endif
  endtask

  task automatic cyc();
    model(0, 2, int'(s_exc[1:0]));
    model(1, 4, int'(s_exc));
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    s_valid = 4'($urandom);
    s_we    = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      s_wa[k] = 5'($urandom);
      s_wd[k] = $urandom;
      s_pc[k] = $urandom;
    end
    s_hi = $urandom; s_lo = $urandom; s_cp0_wd = $urandom;
    s_whilo = 1'($urandom); s_llbit = 1'($urandom); s_llbit_we = 1'($urandom);
    s_cp0_we = 1'($urandom); s_cp0_wa = 5'($urandom); s_cp0_sel = 3'($urandom);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) ml[d][k] = '0;
      ms[d] = '0;
      mret[d] = '0;
    end
    s_rst = 1'b1; s_flush = 1'b0; s_cause = 1'b0; s_clr = 1'b0; s_exc = 3'd0; s_stall = 5'd0;
    rand_inputs();

    // Reset
    cyc();
    cyc();
    chk("rst_valid4", 128'(bus4.valid_o), 128'd0);
    s_rst = 1'b0;

    // Full dual-issue group latched
    s_valid = 4'b1111; s_we = 4'b1111;
    s_wa[0] = 5'd3; s_wa[1] = 5'd4; s_wd[0] = 32'h11; s_wd[1] = 32'h22;
    cyc();
    chk("t1_cnt", 128'(bus2.commit_cnt_o), 128'd2);
    chk("t1_wd1", 128'(bus2.wdata_o[63:32]), 128'h22);
    chk("t1_wa0", 128'(bus2.waddr_o[4:0]), 128'd3);

    // Exception in lane 1
    s_flush = 1'b1; s_cause = 1'b1; s_exc = 3'd1; s_whilo = 1'b1; s_cp0_we = 1'b1;
    cyc();
    chk("t2_valid", 128'(bus2.valid_o), 128'b01);
    chk("t2_we", 128'(bus2.we_o), 128'b01);
    chk("t2_whilo", 128'(bus2.whilo_o), 128'd1);
    chk("t2_cp0we", 128'(bus2.cp0_we_o), 128'd0);
    chk("t2_pc1", 128'(bus2.pc_o[63:32]), 128'd0);
    chk("t2_cnt", 128'(bus2.commit_cnt_o), 128'd1);

    // Exception in lane 0, then non-exception flush
    s_exc = 3'd0;
    cyc();
    chk("t3_valid", 128'(bus2.valid_o), 128'd0);
    s_cause = 1'b0;
    cyc();
    chk("t3_flush_other", 128'(bus2.valid_o), 128'b11);
    s_flush = 1'b0;

    // Bubble, reload, then commit stall holds while inputs churn
    s_stall = 5'b00100;
    cyc();
    chk("t4_bubble", 128'(bus2.commit_cnt_o), 128'd0);
    s_stall = 5'b00000; rand_inputs(); s_valid = 4'b1111;
    cyc();
    s_stall = 5'b01100;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cyc();
      chk("t4_hold_cnt4", 128'(bus4.commit_cnt_o), 128'd4);
    end

    // Wide group, exception in lane 2 (2-lane instance clamps to lane 1)
    s_stall = 5'b00000; s_valid = 4'b1111;
    s_flush = 1'b1; s_cause = 1'b1; s_exc = 3'd2;
    cyc();
    chk("t5_valid4", 128'(bus4.valid_o), 128'b0011);
    chk("t5_valid2", 128'(bus2.valid_o), 128'b01);
    // Illegal lane index on the wide instance clamps to lane 3
    s_exc = 3'd6;
    cyc();
    chk("t5_clamp4", 128'(bus4.valid_o), 128'b0111);
    s_flush = 1'b0;

    // Reset during hold
    s_stall = 5'b01100;
    cyc();
    s_rst = 1'b1;
    cyc();
    chk("t6_rst_cnt4", 128'(bus4.commit_cnt_o), 128'd0);
    s_rst = 1'b0; s_stall = 5'b00000;

`ifdef COMMIT_RETIRE_CNT_EN
    s_rst = 1'b1;
    cyc();
    s_rst = 1'b0; s_valid = 4'b1111;
    for (int i = 0; i < 11; i++) cyc();
    chk("ret_20", 128'(ret2), 128'd20);
    s_clr = 1'b1;
    cyc();
    chk("ret_clr", 128'(ret2), 128'd0);
    s_clr = 1'b0;
`endif

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      s_rst   = ($urandom_range(0, 49) == 0);
      s_flush = ($urandom_range(0, 3) == 0);
      s_cause = 1'($urandom);
      s_exc   = 3'($urandom_range(0, 5));
      s_stall = 5'($urandom);
      if ($urandom_range(0, 2) != 0) s_stall[2] = 1'b0;
      s_clr   = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
